// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and types for the link-fault monitor and its column decoder.
package xgmii_pkg;

    // XGMII control characters and fault sequence codes
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;
    localparam logic [7:0] LF_CODE     = 8'h01;
    localparam logic [7:0] RF_CODE     = 8'h02;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } link_fault_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        LF   = 2'b01,
        RF   = 2'b10
    } seq_type_t;

    // One 64-bit XGMII word: lane 0 in data[7:0] / ctrl[0]
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } xgmii_word_t;

    // Receive-side fault tracking state, updated once per column
    typedef struct packed {
        seq_type_t   last_type;
        logic [2:0]  seq_cnt;
        logic [7:0]  col_cnt;
        link_fault_t link_fault;
    } rx_state_t;

    localparam rx_state_t RX_STATE_RESET = '{
        last_type:  NONE,
        seq_cnt:    3'd0,
        col_cnt:    8'd0,
        link_fault: LF_OK
    };

    // Idle in every lane
    localparam xgmii_word_t XGMII_IDLE_WORD = '{
        data: {8{XGMII_IDLE}},
        ctrl: 8'hFF
    };

    // Remote Fault sequence ordered set in both columns
    localparam xgmii_word_t XGMII_RF_WORD = '{
        data: {2{RF_CODE, 8'h00, 8'h00, XGMII_SEQ}},
        ctrl: 8'h11
    };

    // Map a received sequence type onto the link status it asserts
    function automatic link_fault_t seq_to_fault(input seq_type_t t);
        return (t == RF) ? LF_REMOTE : LF_LOCAL;
    endfunction

endpackage

// File: rtl/xgmii_fault_column_decode.sv
// Classifies one 4-lane XGMII column as a Local Fault, Remote Fault or neither.
module xgmii_fault_column_decode
    import xgmii_pkg::*;
(
    input  logic [31:0] col_data,
    input  logic [3:0]  col_ctrl,
    output seq_type_t   col_type
);

    // Sequence ordered set in lane 0 with zero lanes 1-2; lane 3 selects LF/RF
    always_comb begin
        col_type = NONE;
        if ((col_ctrl == 4'b0001) && (col_data[7:0] == XGMII_SEQ) &&
            (col_data[23:8] == 16'h0000)) begin
            if (col_data[31:24] == LF_CODE) begin
                col_type = LF;
            end else if (col_data[31:24] == RF_CODE) begin
                col_type = RF;
            end
        end
    end

endmodule

// File: rtl/xgmii_link_fault_monitor.sv
// RS link-fault monitor: tracks LF/RF sequences on RX and conditions the MAC TX stream.
module xgmii_link_fault_monitor
    import xgmii_pkg::*;
#(
    parameter int P_FAULT_SEQ_COUNT = 4,
    parameter int P_CLEAR_COLUMNS   = 128,
    parameter int P_COUNTER_WIDTH   = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [63:0]                i_xgmii_rx_data,
    input  logic [7:0]                 i_xgmii_rx_control,
    input  logic                       i_force_local_fault,
    input  logic [63:0]                i_mac_tx_data,
    input  logic [7:0]                 i_mac_tx_control,
    output logic [63:0]                o_xgmii_tx_data,
    output logic [7:0]                 o_xgmii_tx_control,
    output logic [1:0]                 o_link_fault,
    output logic [P_COUNTER_WIDTH-1:0] o_fault_entry_count
);

    localparam logic [2:0] SEQ_THRESHOLD   = 3'(P_FAULT_SEQ_COUNT);
    localparam logic [7:0] CLEAR_THRESHOLD = 8'(P_CLEAR_COLUMNS);

    seq_type_t                  col_type [2];
    rx_state_t                  state_reg;
    rx_state_t                  state_next;
    xgmii_word_t                tx_reg;
    xgmii_word_t                tx_next;
    logic [P_COUNTER_WIDTH-1:0] count_reg;
    logic                       fault_entry;

    // One decoder per column: gi=0 covers lanes 0-3, gi=1 covers lanes 4-7
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_col
            xgmii_fault_column_decode u_decode (
                .col_data (i_xgmii_rx_data[32*gi +: 32]),
                .col_ctrl (i_xgmii_rx_control[4*gi +: 4]),
                .col_type (col_type[gi])
            );
        end
    endgenerate

    // Advance the fault tracker by a single column
    function automatic rx_state_t column_step(input rx_state_t s, input seq_type_t t);
        rx_state_t n;
        n = s;
        if (t != NONE) begin
            n.col_cnt = 8'd0;
            if (t != s.last_type) begin
                n.last_type = t;
                n.seq_cnt   = 3'd1;
            end else if (s.seq_cnt != 3'd7) begin
                n.seq_cnt = s.seq_cnt + 3'd1;
            end
            if (n.seq_cnt >= SEQ_THRESHOLD) begin
                n.link_fault = seq_to_fault(t);
            end
        end else begin
            n.col_cnt = s.col_cnt + 8'd1;
            // Enough clean columns wipes both a pending count and an asserted fault
            if (n.col_cnt == CLEAR_THRESHOLD) begin
                n = RX_STATE_RESET;
            end
        end
        return n;
    endfunction

    // State register for the RX fault tracker
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= RX_STATE_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: column 0 then column 1, unless the PHY forces a local fault
    always_comb begin
        state_next = state_reg;
        if (i_force_local_fault) begin
            state_next = '{
                last_type:  LF,
                seq_cnt:    SEQ_THRESHOLD,
                col_cnt:    8'd0,
                link_fault: LF_LOCAL
            };
        end else begin
            state_next = column_step(column_step(state_reg, col_type[0]), col_type[1]);
        end
    end

    // TX selection from the currently registered link status
    always_comb begin
        tx_next = '{data: i_mac_tx_data, ctrl: i_mac_tx_control};
        case (state_reg.link_fault)
            LF_LOCAL:  tx_next = XGMII_RF_WORD;
            LF_REMOTE: tx_next = XGMII_IDLE_WORD;
            default:   tx_next = '{data: i_mac_tx_data, ctrl: i_mac_tx_control};
        endcase
    end

    // Registered TX word; reset sends Idle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_reg <= XGMII_IDLE_WORD;
        end else begin
            tx_reg <= tx_next;
        end
    end

    // Only OK-to-fault transitions count; LOCAL<->REMOTE swaps do not
    assign fault_entry = (state_reg.link_fault == LF_OK) && (state_next.link_fault != LF_OK);

    // Saturating fault-entry counter
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_reg <= '0;
        end else if (fault_entry && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_xgmii_tx_data     = tx_reg.data;
    assign o_xgmii_tx_control  = tx_reg.ctrl;
    assign o_link_fault        = state_reg.link_fault;
    assign o_fault_entry_count = count_reg;

endmodule

// File: doc/xgmii_link_fault_monitor.md
Name: xgmii_link_fault_monitor

Overview:
Reconciliation-sublayer link-fault stage that sits directly downstream of the SFP+ USXGMII PHY controller's 64-bit XGMII RX output. It detects Local/Remote Fault sequence ordered sets per IEEE 802.3 clause 46 and tracks link_fault status. It also conditions the MAC's XGMII TX stream before that stream reaches the PHY controller's TX input:
- Local fault received: send Remote Fault sequences.
- Remote fault received: send Idle.
- Link OK: pass MAC data through.

Parameters:
P_FAULT_SEQ_COUNT, 4, number of same-type fault sequences needed to declare a fault (range 2..7).
P_CLEAR_COLUMNS, 128, number of consecutive non-fault columns that clear a fault (range 2..255).
P_COUNTER_WIDTH, 16, width of the saturating fault-entry counter.

Ports:
i_clock  in  1  XGMII clock, 156.25 MHz.
i_reset  in  1  Asynchronous reset, active-high.
i_xgmii_rx_data  in  8x8  RX data, lane 0 = bits [7:0]; comes from the PHY controller's RX XGMII output.
i_xgmii_rx_control  in  8  RX control, 1 bit per lane.
i_force_local_fault  in  1  PHY not ready (LOS / TX fault / module absent); forces LOCAL_FAULT.
i_mac_tx_data  in  8x8  TX data from the MAC.
i_mac_tx_control  in  8  TX control from the MAC.
o_xgmii_tx_data  out  8x8  Conditioned TX data; goes to the PHY controller's TX XGMII input.
o_xgmii_tx_control  out  8  Conditioned TX control.
o_link_fault  out  2  Link status: 00 = OK, 01 = LOCAL, 10 = REMOTE.
o_fault_entry_count  out  P_COUNTER_WIDTH  Saturating count of OK-to-fault transitions.

Behaviour:
- Columns and processing order
  - Each 64-bit word holds two columns: c0 = lanes 0-3, c1 = lanes 4-7.
  - c0 is processed before c1 in the same cycle (unrolled). All state is registered after c1.
- Fault column definition
  - ctrl[4h] = 1, data[4h] = 0x9C, ctrl[4h+3:4h+1] = 0, data lanes 4h+1 and 4h+2 = 0x00.
  - data[4h+3] = 0x01 means LF; 0x02 means RF. Any other value means not a fault column.
- State registers
  - last_type ∈ {NONE, LF, RF}, seq_cnt (3 bit), col_cnt (8 bit), link_fault.
  - Reset values: NONE / 0 / 0 / OK.
- Per-column update, fault column of type T
  - col_cnt ← 0.
  - If T ≠ last_type: last_type ← T and seq_cnt ← 1.
  - Otherwise seq_cnt ← seq_cnt+1, saturating at 7.
  - If the new seq_cnt ≥ P_FAULT_SEQ_COUNT: link_fault ← T.
- Per-column update, non-fault column
  - col_cnt ← col_cnt+1.
  - When it reaches P_CLEAR_COLUMNS: link_fault ← OK, last_type ← NONE, seq_cnt ← 0, col_cnt ← 0.
  - This clears both a pending count and an asserted fault.
- i_force_local_fault = 1
  - Overrides the column logic: link_fault ← LOCAL, last_type ← LF, seq_cnt ← P_FAULT_SEQ_COUNT, col_cnt ← 0, every cycle it is high.
  - After deassertion, the normal clearing rule applies (P_CLEAR_COLUMNS clean columns → OK).
- RX status latency: o_link_fault reflects word N on the cycle after word N is sampled (1 cycle).
- TX output path
  - Registered, 1-cycle latency. The selection uses the registered link_fault value of the same cycle the MAC word is sampled.
  - OK: the MAC word passes through unchanged.
  - LOCAL: both columns carry RF sequence; data lanes = 9C,00,00,02 ×2, control = 8'h11.
  - REMOTE: Idle; all lanes 0x07, control = 8'hFF.
  - Switching is column-aligned only; no frame-boundary deferral. A MAC frame cut off mid-packet is acceptable per clause 46.
- o_fault_entry_count
  - Increments when link_fault goes from OK to non-OK, and saturates at all-ones.
  - A direct LOCAL↔REMOTE change does not increment it.
- Reset
  - Asynchronous; takes effect mid-frame immediately.
  - TX output = Idle (0x07×8, ctrl 8'hFF), o_link_fault = 00, counter = 0.
- Simultaneous events within one word
  - c0 = LF and c1 = RF: ends with last_type = RF, seq_cnt = 1.
  - A clear on c0 followed by a fault column on c1 is evaluated in order, so c1 restarts counting.

Decomposition:
- Package xgmii_pkg
  - Constants: XGMII_IDLE 8'h07, XGMII_START 8'hFB, XGMII_TERM 8'hFD, XGMII_ERROR 8'hFE, XGMII_SEQ 8'h9C, LF_CODE 8'h01, RF_CODE 8'h02.
  - Types: link_fault_t enum {LF_OK=2'b00, LF_LOCAL=2'b01, LF_REMOTE=2'b10}, seq_type_t enum {NONE, LF, RF}, and the 64-bit XGMII word struct.
- One combinational sub-module, xgmii_fault_column_decode: 32-bit data + 4-bit ctrl → seq_type_t. It is instantiated twice, once per column.

Test Plan:
1. Reset released, RX all Idle, MAC sends frame (FB, 55..D5) → o_link_fault=00; output equals MAC input delayed 1 cycle; counter=0.
2. RX 2 words, each carrying LF in c0 and c1 (4 columns) → o_link_fault=01 one cycle after the 2nd word; counter=1; TX = 9C000002 ×2, ctrl 8'h11, from the following cycle.
3. RX 2 words of RF ×2 columns → o_link_fault=10; TX = all 0x07, ctrl 8'hFF; MAC input ignored.
4. After the fault in test 2, send 63 Idle words then 1 more (128 columns) → OK exactly after the 64th Idle word; pass-through resumes; counter unchanged.
5. LF, LF, LF, then 200 Idle columns, then LF ×3 → no fault ever declared (gap exceeds P_CLEAR_COLUMNS; recount stops at 3).
6. i_force_local_fault pulsed 1 cycle with RX Idle → o_link_fault=01 next cycle; OK after 64 clean words; counter=1. Assert i_reset mid-fault → outputs return to Idle/00/0 asynchronously.
